mp_regfile: RTL and testbench

Parametrised multi-port integer register file with an integrated busy-bit scoreboard for the superscalar RISC-V core. Provides NRD combinational read ports and NWR posedge write ports with optional same-cycle write-through bypass, deterministic resolution of write-address collisions, and hard-wired x0. Each register carries a pending (busy) bit: set at issue by an allocate port, cleared at writeback. Decode/issue uses these bits to detect RAW hazards. Sits between decode/issue and the writeback stage.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_scoreboard.sv | 62 ++++++
 rtl/mp_regfile.sv | 83 ++++++++
 tb/tb_mp_regfile.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions: default sizes, the zero-register index
// and the write-collision priority selector also used by the issue logic.
package rf_pkg;

  localparam int RF_XLEN      = 32;
  localparam int RF_NREGS     = 32;
  localparam int REG_ZERO     = 0;
  localparam int RF_MAX_PORTS = 8;

  // Highest-index set bit wins; returns 0 when nothing is set.
  function automatic int rf_prio_sel(input logic [RF_MAX_PORTS-1:0] hits);
    int sel;
    sel = 0;
    for (int p = 0; p < RF_MAX_PORTS; p++) begin
      if (hits[p]) sel = p;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: per-register pending flags set at allocate, cleared at
// writeback, wiped by flush; drives per-read-port busy and the full vector.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS  = RF_NREGS,
  parameter int NRD    = 4,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR-1:0]    alloc_en,
  input  logic [NWR*AW-1:0] alloc_addr,
  input  logic              flush,
  output logic [NRD-1:0]    rd_busy,
  output logic [NREGS-1:0]  busy_vec
);

  localparam bit BP = (BYPASS != 0);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_alloc_hit;
  logic [NREGS-1:0] w_wr_hit;
  logic [NREGS-1:0] w_busy_nxt;

  always_comb begin
    w_alloc_hit = '0;
    w_wr_hit    = '0;
    for (int p = 0; p < NWR; p++) begin
      if (alloc_en[p]) w_alloc_hit[alloc_addr[p*AW +: AW]] = 1'b1;
      if (wr_en[p])    w_wr_hit[wr_addr[p*AW +: AW]]       = 1'b1;
    end
    w_alloc_hit[REG_ZERO] = 1'b0;
    w_wr_hit[REG_ZERO]    = 1'b0;
  end

  // Flush over allocate over writeback; x0 can never become pending.
  always_comb begin
    if (flush) w_busy_nxt = '0;
    else       w_busy_nxt = w_alloc_hit | (r_busy & ~w_wr_hit);
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign busy_vec = r_busy;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_busy
    logic [AW-1:0] w_a;
    assign w_a         = rd_addr[gi*AW +: AW];
    assign rd_busy[gi] = r_busy[w_a] & ~(BP & w_wr_hit[w_a]);
  end

endmodule

// File: rtl/mp_regfile.sv
// Multi-port integer register file with hard-wired x0, highest-port-wins
// write collisions, optional write-through bypass and a busy scoreboard.
module mp_regfile
  import rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREGS  = RF_NREGS,
  parameter int NRD    = 4,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NRD*$clog2(NREGS)-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0]            rd_data,
  output logic [NRD-1:0]                 rd_busy,
  input  logic [NWR-1:0]                 wr_en,
  input  logic [NWR*$clog2(NREGS)-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0]            wr_data,
  input  logic [NWR-1:0]                 alloc_en,
  input  logic [NWR*$clog2(NREGS)-1:0]   alloc_addr,
  input  logic                           flush,
  output logic [NREGS-1:0]               busy_vec
);

  localparam int AW = $clog2(NREGS);
  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0] r_mem [NREGS];

  // Ascending port order makes the highest-index port the last assignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) r_mem[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] != AW'(REG_ZERO)))
          r_mem[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]           w_a;
    logic [RF_MAX_PORTS-1:0] w_hits;
    int                      w_sel;

    assign w_a = rd_addr[gi*AW +: AW];

    always_comb begin
      w_hits = '0;
      for (int p = 0; p < NWR; p++)
        w_hits[p] = wr_en[p] && (wr_addr[p*AW +: AW] == w_a) && (w_a != AW'(REG_ZERO));
    end

    assign w_sel = rf_prio_sel(w_hits);

    assign rd_data[gi*XLEN +: XLEN] =
      (w_a == AW'(REG_ZERO)) ? '0 :
      (BP && (|w_hits))      ? wr_data[w_sel*XLEN +: XLEN] :
                               r_mem[w_a];
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .rd_busy    (rd_busy),
    .busy_vec   (busy_vec)
  );

endmodule

// File: tb/tb_mp_regfile.sv
// Bench for mp_regfile: one BYPASS=1 and one BYPASS=0 instance on shared
// stimulus, compared against an array-based architectural model.
module tb_mp_regfile;

  localparam int XLEN = 32, NREGS = 32, NRD = 4, NWR = 2, AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   ra [NRD];
  logic            we [NWR];
  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic            ae [NWR];
  logic [AW-1:0]   aa [NWR];
  logic            fl;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en, alloc_en;
  logic [NWR*AW-1:0]   wr_addr, alloc_addr;
  logic [NWR*XLEN-1:0] wr_data;

  always_comb begin
    for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = ra[i];
    for (int p = 0; p < NWR; p++) begin
      wr_en[p]                  = we[p];
      wr_addr[p*AW +: AW]       = wa[p];
      wr_data[p*XLEN +: XLEN]   = wd[p];
      alloc_en[p]               = ae[p];
      alloc_addr[p*AW +: AW]    = aa[p];
    end
  end

  logic [NRD*XLEN-1:0] rd_data_b1, rd_data_b0;
  logic [NRD-1:0]      rd_busy_b1, rd_busy_b0;
  logic [NREGS-1:0]    busy_vec_b1, busy_vec_b0;

  mp_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b1), .rd_busy(rd_busy_b1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .flush(fl), .busy_vec(busy_vec_b1));

  mp_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b0), .rd_busy(rd_busy_b0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .flush(fl), .busy_vec(busy_vec_b0));

  // Architectural model state
  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_busy [NREGS];

  int tests = 0;
  int fails = 0;

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NRD; i++) ra[i] = '0;
    for (int p = 0; p < NWR; p++) begin
      we[p] = 1'b0; wa[p] = '0; wd[p] = '0; ae[p] = 1'b0; aa[p] = '0;
    end
    fl = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NREGS-1:0] exp_vec;
    for (int i = 0; i < NRD; i++) begin
      int hit;
      logic [XLEN-1:0] d1, d0;
      bit b1, b0;
      hit = -1;
      for (int p = 0; p < NWR; p++)
        if (we[p] && wa[p] == ra[i] && ra[i] != 0) hit = p;
      if (ra[i] == 0) begin
        d1 = '0; d0 = '0; b1 = 0; b0 = 0;
      end else begin
        d0 = m_mem[ra[i]];
        d1 = (hit >= 0) ? wd[hit] : m_mem[ra[i]];
        b0 = m_busy[ra[i]];
        b1 = m_busy[ra[i]] && (hit < 0);
      end
      chk($sformatf("%s b1.rd_data[%0d]", tag, i), rd_data_b1[i*XLEN +: XLEN], d1);
      chk($sformatf("%s b0.rd_data[%0d]", tag, i), rd_data_b0[i*XLEN +: XLEN], d0);
      chk($sformatf("%s b1.rd_busy[%0d]", tag, i), XLEN'(rd_busy_b1[i]), XLEN'(b1));
      chk($sformatf("%s b0.rd_busy[%0d]", tag, i), XLEN'(rd_busy_b0[i]), XLEN'(b0));
    end
    for (int r = 0; r < NREGS; r++) exp_vec[r] = m_busy[r];
    chk({tag, " b1.busy_vec"}, busy_vec_b1, exp_vec);
    chk({tag, " b0.busy_vec"}, busy_vec_b0, exp_vec);
  endtask

  task automatic model_edge();
    bit alloc_hit [NREGS];
    bit wr_hit [NREGS];
    for (int r = 0; r < NREGS; r++) begin
      alloc_hit[r] = 0; wr_hit[r] = 0;
    end
    for (int p = 0; p < NWR; p++) begin
      if (we[p] && wa[p] != 0) begin
        m_mem[wa[p]] = wd[p];
        wr_hit[wa[p]] = 1;
      end
      if (ae[p] && aa[p] != 0) alloc_hit[aa[p]] = 1;
    end
    for (int r = 1; r < NREGS; r++) begin
      if (fl)                m_busy[r] = 0;
      else if (alloc_hit[r]) m_busy[r] = 1;
      else if (wr_hit[r])    m_busy[r] = 0;
    end
    m_busy[0] = 0;
  endtask

  // Check the current inputs, clock them in, and land 1 time unit past the edge.
  task automatic cycle(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic all_read(input logic [AW-1:0] a);
    for (int i = 0; i < NRD; i++) ra[i] = a;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    all_read(5'd5);
    #2;
    check_all("in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("after_reset");

    we[0] = 1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
    cycle("wr_x5");
    idle_inputs(); all_read(5'd5);
    cycle("rd_x5");

    we[0] = 1; wa[0] = 5'd0; wd[0] = 32'hFFFFFFFF; ae[1] = 1; aa[1] = 5'd0;
    all_read(5'd0);
    cycle("wr_x0");
    idle_inputs(); all_read(5'd0);
    cycle("rd_x0");

    we[0] = 1; wa[0] = 5'd7; wd[0] = 32'h11;
    we[1] = 1; wa[1] = 5'd7; wd[1] = 32'h22;
    all_read(5'd7);
    cycle("collide_x7");
    idle_inputs(); all_read(5'd7);
    chk("x7_stored_direct", rd_data_b0[XLEN-1:0], 32'h22);
    cycle("rd_x7");

    ae[0] = 1; aa[0] = 5'd9; all_read(5'd9);
    cycle("alloc_x9");
    idle_inputs(); all_read(5'd9);
    cycle("busy_x9");
    we[1] = 1; wa[1] = 5'd9; wd[1] = 32'h33; all_read(5'd9);
    cycle("wb_x9");
    idle_inputs(); all_read(5'd9);
    cycle("after_wb_x9");

    ae[1] = 1; aa[1] = 5'd4; we[0] = 1; wa[0] = 5'd4; wd[0] = 32'h44; all_read(5'd4);
    cycle("alloc_wr_x4");
    idle_inputs(); all_read(5'd4);
    cycle("after_x4");
    fl = 1; ae[0] = 1; aa[0] = 5'd6; we[1] = 1; wa[1] = 5'd6; wd[1] = 32'h66; all_read(5'd6);
    cycle("flush_x6");
    idle_inputs(); all_read(5'd6);
    cycle("after_flush");

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NRD; i++) ra[i] = AW'($urandom_range(0, 7));
      for (int p = 0; p < NWR; p++) begin
        we[p] = ($urandom_range(0, 2) == 0);
        wa[p] = AW'($urandom_range(0, 7));
        wd[p] = $urandom;
        ae[p] = ($urandom_range(0, 2) == 0);
        aa[p] = AW'($urandom_range(0, 7));
      end
      fl = ($urandom_range(0, 19) == 0);
      cycle("rand");
    end

    for (int r = 1; r < 8; r++) begin
      idle_inputs(); ae[0] = 1; aa[0] = AW'(r); we[1] = 1; wa[1] = AW'(r); wd[1] = 32'hA500_0000 | r;
      cycle("prefill");
    end
    idle_inputs();
    for (int i = 0; i < NRD; i++) ra[i] = AW'(i + 1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("post_reset");
    for (int i = 0; i < NRD; i++) ra[i] = AW'(i + 4);
    cycle("post_reset2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
